// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state type and operand signedness helpers.
package mul_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mul_div_signfix.sv
// FIX-stage combinational block: applies sign correction and the RISC-V
// divide special cases to the raw magnitude datapath, then selects the result.
module mul_div_signfix
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] raw,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic               div_zero,
  input  logic               div_ovf,
  output logic [WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // raw holds {remainder, quotient} for divides and the full product for multiplies
  always_comb begin
    prod = neg_res ? -raw : raw;
    if (div_zero)     quo = '1;
    else if (div_ovf) quo = {1'b1, {(WIDTH-1){1'b0}}};
    else if (neg_res) quo = -raw[WIDTH-1:0];
    else              quo = raw[WIDTH-1:0];
    if (div_ovf)      rem = '0;
    else if (neg_rem) rem = -raw[2*WIDTH-1:WIDTH];
    else              rem = raw[2*WIDTH-1:WIDTH];

    result = '0;
    case (op)
      OP_MUL:    result = prod[WIDTH-1:0];
      OP_MULH:   result = prod[2*WIDTH-1:WIDTH];
      OP_MULHSU: result = prod[2*WIDTH-1:WIDTH];
      OP_MULHU:  result = prod[2*WIDTH-1:WIDTH];
      OP_DIV:    result = quo;
      OP_DIVU:   result = quo;
      OP_REM:    result = rem;
      OP_REMU:   result = rem;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed latency, sign fix-up in a final FIX cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   bmag;
  logic [2:0]         op_q;
  logic [4:0]         rd_q;
  logic               neg_res, neg_rem, div_zero, div_ovf;

  logic               a_neg, b_neg, in_zero, in_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [WIDTH-1:0]   fix_result;

  always_comb begin
    a_neg   = op_a_signed(op) & a[WIDTH-1];
    b_neg   = op_b_signed(op) & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    in_zero = (b == '0);
    in_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
  end

  // Multiply: acc = {partial hi, multiplier}, shifted right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, bmag} & {(WIDTH+1){acc[0]}});
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, bmag};
    if (op_q[2]) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  mul_div_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op       (op_q),
    .raw      (acc),
    .neg_res  (neg_res),
    .neg_rem  (neg_rem),
    .div_zero (div_zero),
    .div_ovf  (div_ovf),
    .result   (fix_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      bmag     <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            acc      <= {{WIDTH{1'b0}}, a_mag};
            bmag     <= b_mag;
            op_q     <= op;
            rd_q     <= rd_in;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= in_zero;
            div_ovf  <= in_ovf;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ITER) state <= FIX;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (kill) begin
            state <= IDLE;
          end else begin
            result <= fix_result;
            rd_out <= rd_q;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
